// File: rtl/trdb_pkt_arbiter.sv
// Round-robin arbiter sharing one trdb_align8 packer between several trace packet emitters.
// Holds one packet in an output register and sequences stream flushes (drain, flush, done).

package trdb_pkg;
    localparam int unsigned PACKET_LEN = 64;
endpackage

module trdb_pkt_arbiter
    import trdb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int unsigned LEN_W   = $clog2(PACKET_LEN),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_SRC*PACKET_LEN-1:0] src_bits_i,
    input  logic [NUM_SRC*LEN_W-1:0]    src_len_i,
    input  logic [NUM_SRC-1:0]          src_valid_i,
    output logic [NUM_SRC-1:0]          src_grant_o,
    output logic [PACKET_LEN-1:0]       payload_bits_o,
    output logic [LEN_W-1:0]            payload_len_o,
    output logic                        valid_o,
    input  logic                        grant_i,
    output logic [SRC_W-1:0]            src_id_o,
    input  logic                        flush_req_i,
    output logic                        flush_stream_o,
    input  logic                        flush_confirm_i,
    output logic                        flush_done_o,
    output logic [CNT_W-1:0]            pkt_cnt_o
);

    // state | meaning
    // RUN   | accepting packets from sources
    // DRAIN | flush requested, waiting for the held packet to be consumed
    // FLUSH | flush_stream_o driven, waiting for the packer's confirm
    // DONE  | one-cycle flush_done_o pulse, then back to RUN
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH, ST_DONE} state_t;

    localparam logic [SRC_W:0] NUM_SRC_X = (SRC_W+1)'(NUM_SRC);

    state_t                 state;
    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       winner;
    logic [SRC_W:0]         cand;
    logic                   found;
    logic                   load;
    logic                   consume;
    logic [2*NUM_SRC-1:0]   rot_valid;
    logic [PACKET_LEN-1:0]  win_bits;
    logic [LEN_W-1:0]       win_len;

    // Rotating a doubled copy puts source rr_ptr at bit 0, so the first set bit wins.
    always_comb begin
        rot_valid = {src_valid_i, src_valid_i} >> rr_ptr;
        found     = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (cand >= NUM_SRC_X) cand = cand - NUM_SRC_X;
            if (!found && rot_valid[i]) begin
                found  = 1'b1;
                winner = cand[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        win_bits = '0;
        win_len  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (winner == SRC_W'(k)) begin
                win_bits = src_bits_i[k*PACKET_LEN +: PACKET_LEN];
                win_len  = src_len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    assign load    = (state == ST_RUN) && !flush_req_i && (!valid_o || grant_i);
    assign consume = valid_o && grant_i;

    always_comb begin
        src_grant_o = '0;
        if (rst_ni && load && found) src_grant_o[winner] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_RUN;
            rr_ptr         <= '0;
            valid_o        <= 1'b0;
            payload_bits_o <= '0;
            payload_len_o  <= '0;
            src_id_o       <= '0;
            flush_stream_o <= 1'b0;
            flush_done_o   <= 1'b0;
            pkt_cnt_o      <= '0;
        end else begin
            if (consume) pkt_cnt_o <= pkt_cnt_o + 1'b1;

            if (load && found) begin
                valid_o        <= 1'b1;
                payload_bits_o <= win_bits;
                payload_len_o  <= win_len;
                src_id_o       <= winner;
                rr_ptr         <= (winner == SRC_W'(NUM_SRC-1)) ? '0 : winner + 1'b1;
            end else if (consume) begin
                valid_o <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (flush_req_i) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!valid_o || grant_i) begin
                        state          <= ST_FLUSH;
                        flush_stream_o <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_confirm_i) begin
                        state          <= ST_DONE;
                        flush_stream_o <= 1'b0;
                        flush_done_o   <= 1'b1;
                    end
                end
                default: begin
                    flush_done_o <= 1'b0;
                    state        <= ST_RUN;
                end
            endcase
        end
    end

endmodule
